i2c_ram_arbiter: RTL and testbench

Two-master arbiter that shares the single-port 51200×32 I2C on-chip RAM between the I2C controller's data mover (master 0) and the system CPU (master 1). Each master sees an Avalon-MM pipelined slave with waitrequest and readdatavalid. The RAM side drives the RAM's address, byteenable, chipselect, write, writedata and clken inputs and consumes its unregistered-output readdata. The block provides round-robin fairness on conflict, a bounded lock for read-modify-write sequences, and read-return routing.

---
 rtl/i2c_ram_arbiter_pkg.sv | 20 ++
 rtl/i2c_ram_rr_pick.sv | 33 +++
 rtl/i2c_ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_i2c_ram_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_ram_arbiter_pkg.sv
// ==========================================================================
// i2c_ram_arbiter_pkg - shared ids and widths for the I2C RAM arbiter
// Rev 1.0
// ==========================================================================
`default_nettype none

package i2c_ram_arbiter_pkg;

   typedef logic mst_id_t;

   localparam mst_id_t M0 = 1'b0;
   localparam mst_id_t M1 = 1'b1;

   localparam int LOCK_CNT_W     = 8;
   localparam int I2C_RAM_ADDR_W = 16;
   localparam int I2C_RAM_DATA_W = 32;

endpackage

`default_nettype wire

// File: rtl/i2c_ram_rr_pick.sv
// ==========================================================================
// i2c_ram_rr_pick - combinational 2-way round-robin pick with lock override
// Rev 1.0
// ==========================================================================
`default_nettype none

module i2c_ram_rr_pick
   import i2c_ram_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  mst_id_t    i_rr_last,
   input  logic       i_own_excl,
   input  mst_id_t    i_own_id,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = 2'b00;
      if (i_own_excl) begin
         // An exclusive owner shuts the other master out even when idle.
         if (i_own_id == M1) o_gnt[1] = i_req[1];
         else                o_gnt[0] = i_req[0];
      end else if (&i_req) begin
         if (i_rr_last == M1) o_gnt[0] = 1'b1;
         else                 o_gnt[1] = 1'b1;
      end else begin
         o_gnt = i_req;
      end
   end

endmodule

`default_nettype wire

// File: rtl/i2c_ram_arbiter.sv
// ==========================================================================
// i2c_ram_arbiter - two-master Avalon-MM arbiter for the shared I2C RAM
// Rev 1.0
// ==========================================================================
`default_nettype none

module i2c_ram_arbiter
   import i2c_ram_arbiter_pkg::*;
#(
   parameter int ADDR_W   = I2C_RAM_ADDR_W,
   parameter int DATA_W   = I2C_RAM_DATA_W,
   parameter int LOCK_MAX = 16
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   i_m0_address,
   input  logic                i_m0_read,
   input  logic                i_m0_write,
   input  logic [DATA_W-1:0]   i_m0_writedata,
   input  logic [DATA_W/8-1:0] i_m0_byteenable,
   input  logic                i_m0_lock,
   output logic                o_m0_waitrequest,
   output logic [DATA_W-1:0]   o_m0_readdata,
   output logic                o_m0_readdatavalid,
   input  logic [ADDR_W-1:0]   i_m1_address,
   input  logic                i_m1_read,
   input  logic                i_m1_write,
   input  logic [DATA_W-1:0]   i_m1_writedata,
   input  logic [DATA_W/8-1:0] i_m1_byteenable,
   input  logic                i_m1_lock,
   output logic                o_m1_waitrequest,
   output logic [DATA_W-1:0]   o_m1_readdata,
   output logic                o_m1_readdatavalid,
   output logic [ADDR_W-1:0]   o_ram_address,
   output logic [DATA_W/8-1:0] o_ram_byteenable,
   output logic [DATA_W-1:0]   o_ram_writedata,
   output logic                o_ram_chipselect,
   output logic                o_ram_write,
   output logic                o_ram_clken,
   input  logic [DATA_W-1:0]   i_ram_readdata
);

   logic [1:0]            w_req;
   logic [1:0]            w_rd;
   logic [1:0]            w_wr;
   logic [1:0]            w_lock;
   logic [1:0]            w_pick;
   logic [1:0]            w_gnt;
   logic                  w_owned;
   logic                  w_excl;
   logic                  w_revoke;
   logic                  w_acc;
   logic                  w_acq_ok;
   mst_id_t               w_gnt_id;
   mst_id_t               w_rr_eff;

   mst_id_t               r_rr_last;
   logic                  r_own_vld;
   mst_id_t               r_own_id;
   logic [LOCK_CNT_W-1:0] r_lock_cnt;
   logic [1:0]            r_reacq_blk;
   logic                  r_rd_pend;
   mst_id_t               r_rd_owner;

   // Write wins when a master raises read and write together.
   assign w_wr   = {i_m1_write, i_m0_write};
   assign w_rd   = {i_m1_read & ~i_m1_write, i_m0_read & ~i_m0_write};
   assign w_req  = {i_m1_read | i_m1_write, i_m0_read | i_m0_write};
   assign w_lock = {i_m1_lock, i_m0_lock};

   assign w_owned  = r_own_vld & w_lock[r_own_id];
   assign w_excl   = w_owned & (r_lock_cnt < LOCK_CNT_W'(LOCK_MAX));
   assign w_revoke = w_owned & ~w_excl;
   assign w_rr_eff = w_revoke ? r_own_id : r_rr_last;

   i2c_ram_rr_pick u_pick (
      .i_req      (w_req),
      .i_rr_last  (w_rr_eff),
      .i_own_excl (w_excl),
      .i_own_id   (r_own_id),
      .o_gnt      (w_pick)
   );

   assign w_gnt    = w_pick & {2{reset_n}};
   assign w_acc    = |w_gnt;
   assign w_gnt_id = w_gnt[1] ? M1 : M0;
   // A revoked owner may not take the lock back in the revoking cycle either.
   assign w_acq_ok = w_acc & w_lock[w_gnt_id] & ~r_reacq_blk[w_gnt_id]
                   & ~(w_revoke & (r_own_id == w_gnt_id));

   assign o_m0_waitrequest   = ~reset_n | (w_req[0] & ~w_gnt[0]);
   assign o_m1_waitrequest   = ~reset_n | (w_req[1] & ~w_gnt[1]);
   assign o_m0_readdata      = i_ram_readdata;
   assign o_m1_readdata      = i_ram_readdata;
   assign o_m0_readdatavalid = r_rd_pend & (r_rd_owner == M0);
   assign o_m1_readdatavalid = r_rd_pend & (r_rd_owner == M1);

   assign o_ram_chipselect = w_acc;
   assign o_ram_write      = |(w_gnt & w_wr);
   assign o_ram_clken      = reset_n;
   assign o_ram_address    = ({ADDR_W{w_gnt[0]}} & i_m0_address)
                           | ({ADDR_W{w_gnt[1]}} & i_m1_address);
   assign o_ram_writedata  = ({DATA_W{w_gnt[0]}} & i_m0_writedata)
                           | ({DATA_W{w_gnt[1]}} & i_m1_writedata);
   assign o_ram_byteenable = ({(DATA_W/8){w_gnt[0]}} & i_m0_byteenable)
                           | ({(DATA_W/8){w_gnt[1]}} & i_m1_byteenable);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_last   <= M1;
         r_own_vld   <= 1'b0;
         r_own_id    <= M0;
         r_lock_cnt  <= '0;
         r_reacq_blk <= 2'b00;
         r_rd_pend   <= 1'b0;
         r_rd_owner  <= M0;
      end else begin
         if (w_acc) begin
            r_rr_last  <= w_gnt_id;
            r_rd_owner <= w_gnt_id;
         end
         r_rd_pend <= |(w_gnt & w_rd);

         if (w_excl) begin
            r_lock_cnt <= r_lock_cnt + LOCK_CNT_W'(1);
         end else if (w_acq_ok) begin
            r_own_vld  <= 1'b1;
            r_own_id   <= w_gnt_id;
            r_lock_cnt <= '0;
         end else begin
            r_own_vld  <= 1'b0;
            r_lock_cnt <= '0;
         end

         for (int n = 0; n < 2; n++) begin
            if (w_revoke && (r_own_id == mst_id_t'(n)))
               r_reacq_blk[n] <= 1'b1;
            else if (!w_lock[n] && (w_gnt[n] || !w_req[n]))
               r_reacq_blk[n] <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_i2c_ram_arbiter.sv
// ==========================================================================
// tb_i2c_ram_arbiter - scoreboard bench with RAM model and reference arbiter
// Rev 1.0
// ==========================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_ram_arbiter;

   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int BW   = DW/8;
   localparam int LMAX = 16;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] m_addr [2];
   logic          m_rd   [2];
   logic          m_wr   [2];
   logic          m_lock [2];
   logic [DW-1:0] m_wd   [2];
   logic [BW-1:0] m_be   [2];

   logic          w0, w1, rv0, rv1;
   logic [DW-1:0] rd0, rd1;
   logic [AW-1:0] ram_addr;
   logic [BW-1:0] ram_be;
   logic [DW-1:0] ram_wd;
   logic [DW-1:0] ram_q;
   logic          ram_cs, ram_we, ram_clken;

   logic [DW-1:0] ram_mem [0:65535];
   logic [DW-1:0] ref_mem [0:65535];
   exp_t          q0 [$];
   exp_t          q1 [$];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // reference arbiter state: who wins the next conflict, lock holder, etc.
   int  turn;
   int  holder;
   int  hold_cyc;
   bit  barred [2];
   bit  acc    [2];

   logic          s_w0, s_w1, s_rv0, s_rv1;
   logic [DW-1:0] s_rd0, s_rd1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   i2c_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .i_m0_address       (m_addr[0]),
      .i_m0_read          (m_rd[0]),
      .i_m0_write         (m_wr[0]),
      .i_m0_writedata     (m_wd[0]),
      .i_m0_byteenable    (m_be[0]),
      .i_m0_lock          (m_lock[0]),
      .o_m0_waitrequest   (w0),
      .o_m0_readdata      (rd0),
      .o_m0_readdatavalid (rv0),
      .i_m1_address       (m_addr[1]),
      .i_m1_read          (m_rd[1]),
      .i_m1_write         (m_wr[1]),
      .i_m1_writedata     (m_wd[1]),
      .i_m1_byteenable    (m_be[1]),
      .i_m1_lock          (m_lock[1]),
      .o_m1_waitrequest   (w1),
      .o_m1_readdata      (rd1),
      .o_m1_readdatavalid (rv1),
      .o_ram_address      (ram_addr),
      .o_ram_byteenable   (ram_be),
      .o_ram_writedata    (ram_wd),
      .o_ram_chipselect   (ram_cs),
      .o_ram_write        (ram_we),
      .o_ram_clken        (ram_clken),
      .i_ram_readdata     (ram_q)
   );

   // single-port RAM with registered address, q valid the cycle after a read
   always @(posedge clk) begin
      if (ram_cs && ram_clken) begin
         if (ram_we) begin
            for (int b = 0; b < BW; b++)
               if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wd[8*b +: 8];
         end else begin
            ram_q <= ram_mem[ram_addr];
         end
      end
   end

   task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, want);
      end
   endtask

   task automatic mon(input int n, input logic v, input logic [DW-1:0] d);
      exp_t e;
      bit   have;
      have = 1'b0;
      e.due = 0;
      e.data = '0;
      if (n == 0) begin
         if (q0.size() > 0 && q0[0].due <= cyc) begin e = q0.pop_front(); have = 1'b1; end
      end else begin
         if (q1.size() > 0 && q1[0].due <= cyc) begin e = q1.pop_front(); have = 1'b1; end
      end
      if (v === 1'b1) begin
         tests++;
         if (!have) begin
            fails++;
            $display("FAIL rvalid_unexpected m%0d cyc=%0d got=1 expected=0", n, cyc);
         end else if (e.due != cyc || d !== e.data) begin
            fails++;
            $display("FAIL rdata m%0d cyc=%0d got=%h expected=%h (due %0d)", n, cyc, d, e.data, e.due);
         end
      end else if (have) begin
         tests++;
         fails++;
         $display("FAIL rvalid_missing m%0d cyc=%0d got=0 expected=1", n, cyc);
      end
   endtask

   always @(negedge clk) begin
      mon(0, rv0, rd0);
      mon(1, rv1, rd1);
   end

   task automatic model_reset();
      turn     = 0;
      holder   = -1;
      hold_cyc = 0;
      barred[0] = 1'b0;
      barred[1] = 1'b0;
   endtask

   task automatic set_m(input int n, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be, input logic lk);
      m_rd[n] = rd; m_wr[n] = wr; m_addr[n] = a; m_wd[n] = d; m_be[n] = be; m_lock[n] = lk;
   endtask

   task automatic idle_all();
      for (int n = 0; n < 2; n++) set_m(n, 1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   // One bus cycle: predict the winner from the arbitration rules, compare at
   // the falling edge, book the effects, then return just after the rising edge.
   task automatic step();
      bit            rq [2];
      int            win, old;
      bit            excl, expired;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [BW-1:0] eb;
      exp_t          e;
      @(negedge clk);
      s_w0 = w0; s_w1 = w1; s_rv0 = rv0; s_rv1 = rv1; s_rd0 = rd0; s_rd1 = rd1;
      for (int n = 0; n < 2; n++) rq[n] = m_rd[n] | m_wr[n];
      excl = 1'b0; expired = 1'b0; old = holder;
      if (holder >= 0) begin
         if (m_lock[holder]) begin
            if (hold_cyc < LMAX) excl = 1'b1;
            else begin expired = 1'b1; turn = 1 - holder; end
         end
      end
      win = -1;
      if (excl) begin
         if (rq[holder]) win = holder;
      end else if (rq[0] && rq[1]) win = turn;
      else if (rq[0]) win = 0;
      else if (rq[1]) win = 1;

      ea = '0; ed = '0; eb = '0;
      if (win >= 0) begin ea = m_addr[win]; ed = m_wd[win]; eb = m_be[win]; end
      chk("waitrequest0", w0, rq[0] && win != 0);
      chk("waitrequest1", w1, rq[1] && win != 1);
      chk("ram_chipselect", ram_cs, win >= 0);
      chk("ram_write", ram_we, win >= 0 && m_wr[win]);
      chk("ram_clken", ram_clken, 1'b1);
      chk("ram_address", ram_addr, ea);
      if (win >= 0 && m_wr[win]) begin
         chk("ram_writedata", ram_wd, ed);
         chk("ram_byteenable", ram_be, eb);
      end

      acc[0] = (win == 0);
      acc[1] = (win == 1);
      if (win >= 0) begin
         turn = 1 - win;
         if (m_wr[win]) begin
            for (int b = 0; b < BW; b++)
               if (eb[b]) ref_mem[ea][8*b +: 8] = ed[8*b +: 8];
         end else begin
            e.due = cyc + 1;
            e.data = ref_mem[ea];
            if (win == 0) q0.push_back(e); else q1.push_back(e);
         end
      end

      if (excl) hold_cyc++;
      else begin
         if (expired) barred[old] = 1'b1;
         holder = -1;
         hold_cyc = 0;
         if (win >= 0 && m_lock[win] && !barred[win]) holder = win;
      end
      for (int n = 0; n < 2; n++)
         if (!m_lock[n] && (win == n || !rq[n])) barred[n] = 1'b0;

      @(posedge clk);
      #1;
   endtask

   int waits;
   bit pend [2];
   int lock_left [2];
   int k;

   initial begin
      for (int i = 0; i < 65536; i++) begin ram_mem[i] = '0; ref_mem[i] = '0; end
      ram_q = '0;
      idle_all();
      model_reset();

      // requests during reset must be held off
      m_rd[0] = 1'b1; m_wr[1] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_waitrequest0", w0, 1'b1);
      chk("rst_waitrequest1", w1, 1'b1);
      chk("rst_chipselect", ram_cs, 1'b0);
      chk("rst_write", ram_we, 1'b0);
      chk("rst_clken", ram_clken, 1'b0);
      chk("rst_rvalid0", rv0, 1'b0);
      chk("rst_rvalid1", rv1, 1'b0);
      @(posedge clk); #1;

      // both masters read every cycle from reset
      idle_all();
      set_m(0, 1'b1, 1'b0, 16'h0100, '0, 4'hF, 1'b0);
      set_m(1, 1'b1, 1'b0, 16'h0200, '0, 4'hF, 1'b0);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i == 0) chk("first_conflict_m0", s_w0, 1'b0);
         for (int n = 0; n < 2; n++) if (acc[n]) m_addr[n] = m_addr[n] + 16'd1;
      end
      idle_all(); step();

      // write then read back on master 0
      set_m(0, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0); step();
      set_m(0, 1'b1, 1'b0, 16'h0010, '0, 4'hF, 1'b0); step();
      idle_all(); step();
      chk("m0_readback_valid", s_rv0, 1'b1);
      chk("m0_readback_data", s_rd0, 32'hDEADBEEF);
      chk("m1_no_valid", s_rv1, 1'b0);

      // partial byte write on master 1 at the top word
      set_m(1, 1'b0, 1'b1, 16'hC7FF, 32'hFFFFFFFF, 4'hF, 1'b0); step();
      set_m(1, 1'b0, 1'b1, 16'hC7FF, 32'h1234ABCD, 4'h3, 1'b0); step();
      set_m(1, 1'b1, 1'b0, 16'hC7FF, '0, 4'hF, 1'b0); step();
      idle_all(); step();
      chk("m1_partial_valid", s_rv1, 1'b1);
      chk("m1_partial_data", s_rd1, 32'hFFFFABCD);

      // lock held by master 0 until the counter expires
      set_m(0, 1'b1, 1'b0, 16'h0020, '0, 4'hF, 1'b1); step();
      set_m(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      set_m(1, 1'b1, 1'b0, 16'h0021, '0, 4'hF, 1'b0);
      waits = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!s_w1) break;
         waits++;
      end
      chk("lock_wait_cycles", waits, LMAX);
      set_m(0, 1'b1, 1'b0, 16'h0022, '0, 4'hF, 1'b1);
      set_m(1, 1'b0, 1'b0, '0, '0, '0, 1'b0); step();
      set_m(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      set_m(1, 1'b1, 1'b0, 16'h0023, '0, 4'hF, 1'b0); step();
      chk("no_relock_m1_granted", s_w1, 1'b0);
      set_m(0, 1'b1, 1'b0, 16'h0024, '0, 4'hF, 1'b0);
      set_m(1, 1'b0, 1'b0, '0, '0, '0, 1'b0); step();
      set_m(0, 1'b1, 1'b0, 16'h0025, '0, 4'hF, 1'b1); step();
      set_m(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      set_m(1, 1'b1, 1'b0, 16'h0026, '0, 4'hF, 1'b0); step();
      chk("relock_excludes_m1", s_w1, 1'b1);
      m_lock[0] = 1'b0; step();
      chk("unlock_same_cycle_m1", s_w1, 1'b0);
      idle_all(); step();

      // reset in the cycle after an accepted read drops the return
      set_m(0, 1'b1, 1'b0, 16'h0010, '0, 4'hF, 1'b0); step();
      idle_all();
      reset_n = 1'b0;
      q0.delete(); q1.delete();
      model_reset();
      @(negedge clk);
      chk("rst_drops_rvalid0", rv0, 1'b0);
      chk("rst_drops_rvalid1", rv1, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      step();
      chk("idle_waitrequest0", s_w0, 1'b0);
      chk("idle_waitrequest1", s_w1, 1'b0);
      set_m(0, 1'b1, 1'b0, 16'h0010, '0, 4'hF, 1'b0);
      set_m(1, 1'b1, 1'b0, 16'hC7FF, '0, 4'hF, 1'b0); step();
      chk("post_rst_conflict_w0", s_w0, 1'b0);
      chk("post_rst_conflict_w1", s_w1, 1'b1);
      idle_all(); step(); step();

      // randomized traffic with occasional locks
      pend[0] = 1'b0; pend[1] = 1'b0; lock_left[0] = 0; lock_left[1] = 0;
      for (int c = 0; c < 2000; c++) begin
         for (int n = 0; n < 2; n++) begin
            if (lock_left[n] > 0) lock_left[n]--;
            else if ($urandom_range(0, 99) < 4) lock_left[n] = $urandom_range(1, 24);
            m_lock[n] = (lock_left[n] > 0);
            if (!pend[n]) begin
               if ($urandom_range(0, 99) < 65) begin
                  k = $urandom_range(0, 9);
                  m_rd[n]   = (k < 5) || (k == 9);
                  m_wr[n]   = (k >= 5);
                  m_addr[n] = (k == 8 || k == 3) ? 16'hC7FF : 16'h0040 + 16'($urandom_range(0, 7));
                  m_wd[n]   = $urandom;
                  m_be[n]   = 4'($urandom_range(0, 15));
                  pend[n]   = 1'b1;
               end else begin
                  m_rd[n] = 1'b0;
                  m_wr[n] = 1'b0;
               end
            end
         end
         step();
         for (int n = 0; n < 2; n++)
            if (acc[n]) begin pend[n] = 1'b0; m_rd[n] = 1'b0; m_wr[n] = 1'b0; end
      end
      idle_all();
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
